crypto_engine_stub: RTL
=======================

// Module: crypto_engine_stub
// PURPOSE
//  Parametrised behavioural stand-in for an AHB-lite crypto engine (ECC/HMAC class) for FPGA builds.
//  Unlike an empty stub, it decodes a register map and runs a fixed-latency "operation" FSM.
//  Results are deterministic and checkable; it drives busy and error/notification interrupts.
//  It sits on the AHB-lite fabric in the slot of the real engine, so firmware flows run end-to-end.
// PARAMETERS
//  AHB_ADDR_WIDTH  32           address bus width; only haddr[7:0] is decoded
//  AHB_DATA_WIDTH  32           data bus width; fixed at 32 (elaboration error otherwise)
//  NUM_WORDS       12           DIN/DOUT register depth, 1..16
//  LATENCY         8            cycles from accepted start to result valid, >=1
//  ID_VALUE        32'h4543_4331  value returned by the NAME register
// PORTS
//  clk          in   1   clock
//  reset        in   1   synchronous, active-high reset
//  haddr_i      in   AAW AHB address
//  hwdata_i     in   ADW AHB write data (data phase)
//  hsel_i       in   1   slave select
//  hwrite_i     in   1   1=write
//  hready_i     in   1   bus ready
//  htrans_i     in   2   transfer type
//  hsize_i      in   3   transfer size
//  hresp_o      out  1   1=ERROR
//  hreadyout_o  out  1   slave ready
//  hrdata_o     out  ADW read data
//  busy_o       out  1   operation in progress
//  error_intr   out  1   level, error status AND enable
//  notif_intr   out  1   level, done status AND enable
//  Interface: one clock; reset is synchronous and active-high.
// BEHAVIOUR
//  Reset: hresp_o=0, hreadyout_o=1, hrdata_o=0, busy_o=0, both intrs=0, all registers 0, FSM=IDLE.
//  AHB address phase is accepted when hsel_i & hready_i & htrans_i[1].
//    The address, write and size are registered; the data phase is the next cycle.
//  Data phase, OK case:
//    Zero wait states; writes use hwdata_i this cycle.
//    Reads: hrdata_o is a combinational mux of the registered address.
//  ERROR (unmapped address, or hsize_i!=3'b010):
//    Cycle 1: hresp=1, hreadyout=0. Cycle 2: hresp=1, hreadyout=1.
//    No register is modified; hrdata_o=0.
//  Map (byte offsets):
//    0x00 NAME RO = ID_VALUE
//    0x04 CTRL WO: [1:0] cmd (0 nop, 1 keygen, 2 sign, 3 verify); [2] zeroize. Reads return 0.
//    0x08 STATUS RO: [0] ready (=IDLE), [1] valid
//    0x0C INTR_STS: [0] notif, [1] error; W1C
//    0x10 INTR_EN RW [1:0]
//    0x40+4i DIN[i] RW, i<NUM_WORDS
//    0x80+4i DOUT[i] RO, i<NUM_WORDS; a write is accepted with OKAY and ignored
//  FSM IDLE->BUSY on a CTRL write with cmd!=0 while IDLE:
//    Clears valid and loads cnt=LATENCY-1. busy_o=1 from the next cycle.
//  BUSY: cnt decrements each cycle. At cnt==0 the FSM returns to IDLE and, on the same edge:
//    DOUT is written, valid=1 and INTR_STS.notif=1.
//    Done is therefore LATENCY cycles after the CTRL data phase.
//  Results are computed from DIN as sampled at completion:
//    cmd1: DOUT[i]=~DIN[i]
//    cmd2: DOUT[i]=DIN[i] rotated left by 1
//    cmd3: DOUT[i]=DIN[i]
//  Errors set INTR_STS.error; the offending write is ignored:
//    CTRL cmd!=0 while BUSY
//    DIN write while BUSY
//  Zeroize (CTRL[2]=1), in any state:
//    Clears DIN, DOUT and valid; aborts BUSY to IDLE with no notif.
//    Zeroize has priority over the cmd in the same write.
//  Same-cycle set and W1C clear of an INTR_STS bit: set wins.
//  DOUT reads during BUSY return the previous results.
//  Reset mid-operation: everything returns to reset values; no completion is produced.
// TESTING
//  1. Reset, read 0x00 -> 32'h45434331. Read 0x08 -> 32'h1.
//  2. Write DIN[0]=32'h8000_0001, INTR_EN=3, CTRL=2.
//     -> busy_o=1 for 8 cycles; notif_intr=1; DOUT[0]=32'h0000_0003; STATUS=3.
//  3. CTRL=1 while BUSY -> INTR_STS=2'b10 and error_intr=1; the result still follows the first cmd.
//     W1C 2 -> error_intr=0.
//  4. Read 0xFC, and a read with hsize=0 -> two-cycle ERROR response; no state change.
//  5. Start cmd3, write CTRL=3'b100 after 3 cycles -> busy_o drops next cycle.
//     DIN/DOUT read 0, notif stays 0.
//  6. Assert reset for 1 cycle mid-BUSY -> all outputs at reset values; no notif after LATENCY.

Source files
------------

// File: rtl/crypto_engine_stub.sv
// Behavioural AHB-lite stand-in for a crypto engine: register map, fixed-latency
// operation FSM with deterministic results, busy flag and level interrupts.
module crypto_engine_stub #(
  parameter int          AHB_ADDR_WIDTH = 32,
  parameter int          AHB_DATA_WIDTH = 32,
  parameter int          NUM_WORDS      = 12,
  parameter int          LATENCY        = 8,
  parameter logic [31:0] ID_VALUE       = 32'h4543_4331
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [AHB_ADDR_WIDTH-1:0] haddr_i,
  input  logic [AHB_DATA_WIDTH-1:0] hwdata_i,
  input  logic                      hsel_i,
  input  logic                      hwrite_i,
  input  logic                      hready_i,
  input  logic [1:0]                htrans_i,
  input  logic [2:0]                hsize_i,
  output logic                      hresp_o,
  output logic                      hreadyout_o,
  output logic [AHB_DATA_WIDTH-1:0] hrdata_o,
  output logic                      busy_o,
  output logic                      error_intr,
  output logic                      notif_intr
);

  localparam int             CNT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  generate
    if (AHB_DATA_WIDTH != 32) begin : g_bad_data_width
      $error("crypto_engine_stub: AHB_DATA_WIDTH must be 32");
    end
    if (NUM_WORDS < 1 || NUM_WORDS > 16) begin : g_bad_num_words
      $error("crypto_engine_stub: NUM_WORDS must be 1..16");
    end
    if (LATENCY < 1) begin : g_bad_latency
      $error("crypto_engine_stub: LATENCY must be >= 1");
    end
    if (AHB_ADDR_WIDTH <= 8) begin : g_bad_addr_width
      $error("crypto_engine_stub: AHB_ADDR_WIDTH must exceed 8");
    end
  endgenerate

  typedef enum logic {ST_IDLE, ST_BUSY} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cmd_q, cmd_d;
  logic             valid_q, valid_d;
  logic [1:0]       sts_q, sts_d;
  logic [1:0]       en_q, en_d;
  logic [31:0]      din_q  [NUM_WORDS];
  logic [31:0]      din_d  [NUM_WORDS];
  logic [31:0]      dout_q [NUM_WORDS];
  logic [31:0]      dout_d [NUM_WORDS];

  // Registered AHB address phase, plus the second cycle of an ERROR response.
  logic             dp_q, dp_d;
  logic [7:0]       addr_q, addr_d;
  logic             write_q, write_d;
  logic             size_ok_q, size_ok_d;
  logic             err2_q, err2_d;

  logic [31:0] wdata;
  logic [3:0]  idx;
  logic        in_range, word_aligned;
  logic        is_name, is_ctrl, is_status, is_sts, is_en, is_din, is_dout;
  logic        bad, wr_en, rd_en;
  logic [1:0]  set_sts, w1c;
  logic [31:0] rdata;
  logic        unused_bits;

  assign wdata        = hwdata_i[31:0];
  assign unused_bits  = ^{haddr_i[AHB_ADDR_WIDTH-1:8], htrans_i[0]};

  assign idx          = addr_q[5:2];
  assign in_range     = ({1'b0, idx} < 5'(NUM_WORDS));
  assign word_aligned = (addr_q[1:0] == 2'b00);
  assign is_name      = (addr_q == 8'h00);
  assign is_ctrl      = (addr_q == 8'h04);
  assign is_status    = (addr_q == 8'h08);
  assign is_sts       = (addr_q == 8'h0C);
  assign is_en        = (addr_q == 8'h10);
  assign is_din       = (addr_q[7:6] == 2'b01) && word_aligned && in_range;
  assign is_dout      = (addr_q[7:6] == 2'b10) && word_aligned && in_range;
  assign bad          = !(is_name || is_ctrl || is_status || is_sts || is_en || is_din || is_dout)
                        || !size_ok_q;
  assign wr_en        = dp_q && !bad && write_q;
  assign rd_en        = dp_q && !bad && !write_q;

  assign hresp_o      = (dp_q && bad) || err2_q;
  assign hreadyout_o  = !(dp_q && bad);
  assign hrdata_o     = rdata;
  assign busy_o       = (state_q == ST_BUSY);
  assign error_intr   = sts_q[1] & en_q[1];
  assign notif_intr   = sts_q[0] & en_q[0];

  always_comb begin
    rdata = 32'h0;
    if (rd_en) begin
      if (is_name)   rdata = ID_VALUE;
      if (is_status) rdata = {30'h0, valid_q, (state_q == ST_IDLE)};
      if (is_sts)    rdata = {30'h0, sts_q};
      if (is_en)     rdata = {30'h0, en_q};
      for (int i = 0; i < NUM_WORDS; i++) begin
        if (is_din  && idx == 4'(i)) rdata = din_q[i];
        if (is_dout && idx == 4'(i)) rdata = dout_q[i];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cmd_d     = cmd_q;
    valid_d   = valid_q;
    en_d      = en_q;
    din_d     = din_q;
    dout_d    = dout_q;
    set_sts   = 2'b00;
    w1c       = 2'b00;
    dp_d      = hsel_i && hready_i && htrans_i[1];
    addr_d    = addr_q;
    write_d   = write_q;
    size_ok_d = size_ok_q;
    err2_d    = dp_q && bad;

    if (dp_d) begin
      addr_d    = haddr_i[7:0];
      write_d   = hwrite_i;
      size_ok_d = (hsize_i == 3'b010);
    end

    // Operation progress first, so a same-cycle zeroize can override completion.
    if (state_q == ST_BUSY) begin
      if (cnt_q == '0) begin
        state_d    = ST_IDLE;
        valid_d    = 1'b1;
        set_sts[0] = 1'b1;
        for (int i = 0; i < NUM_WORDS; i++) begin
          case (cmd_q)
            2'd1:    dout_d[i] = ~din_q[i];
            2'd2:    dout_d[i] = {din_q[i][30:0], din_q[i][31]};
            default: dout_d[i] = din_q[i];
          endcase
        end
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
    end

    if (wr_en && is_ctrl) begin
      if (wdata[2]) begin
        state_d    = ST_IDLE;
        valid_d    = 1'b0;
        set_sts[0] = 1'b0;
        for (int i = 0; i < NUM_WORDS; i++) begin
          din_d[i]  = 32'h0;
          dout_d[i] = 32'h0;
        end
      end else if (wdata[1:0] != 2'd0) begin
        if (state_q == ST_IDLE) begin
          state_d = ST_BUSY;
          cmd_d   = wdata[1:0];
          cnt_d   = CNT_LOAD;
          valid_d = 1'b0;
        end else begin
          set_sts[1] = 1'b1;
        end
      end
    end

    if (wr_en && is_din) begin
      if (state_q == ST_BUSY) begin
        set_sts[1] = 1'b1;
      end else begin
        for (int i = 0; i < NUM_WORDS; i++) begin
          if (idx == 4'(i)) din_d[i] = wdata;
        end
      end
    end

    if (wr_en && is_sts) w1c  = wdata[1:0];
    if (wr_en && is_en)  en_d = wdata[1:0];

    sts_d = (sts_q & ~w1c) | set_sts;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      cmd_q     <= 2'd0;
      valid_q   <= 1'b0;
      sts_q     <= 2'b00;
      en_q      <= 2'b00;
      din_q     <= '{default: '0};
      dout_q    <= '{default: '0};
      dp_q      <= 1'b0;
      addr_q    <= 8'h0;
      write_q   <= 1'b0;
      size_ok_q <= 1'b0;
      err2_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cmd_q     <= cmd_d;
      valid_q   <= valid_d;
      sts_q     <= sts_d;
      en_q      <= en_d;
      din_q     <= din_d;
      dout_q    <= dout_d;
      dp_q      <= dp_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      size_ok_q <= size_ok_d;
      err2_q    <= err2_d;
    end
  end

endmodule
